// File: rtl/imem_boot_loader_pkg.sv
// ----------------------------------------------------------------------------
// imem_boot_loader_pkg
// Shared definitions for the instruction-memory boot loader: the loader FSM
// state encoding, the instruction word width and a small helper that tells
// whether a given state is willing to take bytes from the serial link.
// ----------------------------------------------------------------------------
package imem_boot_loader_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [2:0] {
        ST_LEN_HI = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_DATA   = 3'd2,
        ST_CHECK  = 3'd3,
        ST_RUN    = 3'd4,
        ST_ERR    = 3'd5
    } boot_state_t;

    // RUN and ERR are terminal; every other state is consuming a boot frame.
    function automatic logic state_accepts_bytes(input boot_state_t s);
        return (s == ST_LEN_HI) || (s == ST_LEN_LO) ||
               (s == ST_DATA)   || (s == ST_CHECK);
    endfunction

endpackage

// File: rtl/imem_boot_loader.sv
// ----------------------------------------------------------------------------
// imem_boot_loader
// Receives a boot frame over a byte stream (LEN_HI, LEN_LO, 4*N payload bytes,
// XOR checksum), writes the big-endian words into instruction memory and
// releases the processor reset once the checksum matches.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   rst        : asynchronous active-high reset
//   rx_data    : incoming boot byte
//   rx_valid   : rx_data is valid this cycle
//   rx_ready   : loader accepts a byte (transfer when rx_valid && rx_ready)
//   imem_we    : one-cycle instruction-memory write strobe
//   imem_addr  : word address of the write
//   imem_wdata : instruction word of the write
//   cpu_rst    : processor reset, released only in RUN
//   done       : frame loaded and checksum matched
//   error      : frame aborted (oversize length or bad checksum)
// ----------------------------------------------------------------------------
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              error
);

    // Memory depth as a 17-bit value so that it compares cleanly against the
    // 16-bit word count widened by one bit.
    localparam logic [16:0] DEPTH = 17'(2 ** ADDR_W);

    boot_state_t       state_q,    state_d;
    logic              rdy_q,      rdy_d;
    logic [15:0]       len_q,      len_d;
    logic [15:0]       word_cnt_q, word_cnt_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [23:0]       shift_q,    shift_d;
    logic [7:0]        csum_q,     csum_d;
    logic [ADDR_W-1:0] wr_ptr_q,   wr_ptr_d;
    logic              we_q,       we_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic [WORD_W-1:0] wdata_q,    wdata_d;

    logic        accept;
    logic [16:0] len_full;

    assign accept   = rx_valid && rdy_q;
    assign len_full = {1'b0, len_q[15:8], rx_data};

    // rx_ready is registered so that it stays low while rst is held and rises
    // on the first edge after release; it follows the state being entered.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_cnt_d = word_cnt_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        csum_d     = csum_q;
        wr_ptr_d   = wr_ptr_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;

        case (state_q)
            ST_LEN_HI: begin
                if (accept) begin
                    len_d[15:8] = rx_data;
                    state_d     = ST_LEN_LO;
                end
            end

            ST_LEN_LO: begin
                if (accept) begin
                    len_d      = len_full[15:0];
                    word_cnt_d = 16'd0;
                    byte_cnt_d = 2'd0;
                    if (len_full > DEPTH) begin
                        state_d = ST_ERR;
                    end else if (len_full == 17'd0) begin
                        state_d = ST_CHECK;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end

            ST_DATA: begin
                if (accept) begin
                    csum_d = csum_q ^ rx_data;
                    if (byte_cnt_q == 2'd3) begin
                        // Fourth byte closes the word: the write strobe is
                        // registered so it appears in the following cycle.
                        we_d       = 1'b1;
                        wdata_d    = {shift_q, rx_data};
                        addr_d     = wr_ptr_q;
                        wr_ptr_d   = wr_ptr_q + 1'b1;
                        byte_cnt_d = 2'd0;
                        word_cnt_d = word_cnt_q + 16'd1;
                        if (word_cnt_q == (len_q - 16'd1)) begin
                            state_d = ST_CHECK;
                        end
                    end else begin
                        shift_d    = {shift_q[15:0], rx_data};
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                end
            end

            ST_CHECK: begin
                if (accept) begin
                    state_d = (rx_data == csum_q) ? ST_RUN : ST_ERR;
                end
            end

            ST_RUN:  state_d = ST_RUN;
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_ERR;
        endcase

        rdy_d = state_accepts_bytes(state_d);
    end

    // All loader state; rst clears everything, including a pending write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_LEN_HI;
            rdy_q      <= 1'b0;
            len_q      <= '0;
            word_cnt_q <= '0;
            byte_cnt_q <= '0;
            shift_q    <= '0;
            csum_q     <= '0;
            wr_ptr_q   <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            rdy_q      <= rdy_d;
            len_q      <= len_d;
            word_cnt_q <= word_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            csum_q     <= csum_d;
            wr_ptr_q   <= wr_ptr_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    assign rx_ready   = rdy_q;
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign cpu_rst    = (state_q != ST_RUN);
    assign done       = (state_q == ST_RUN);
    assign error      = (state_q == ST_ERR);

endmodule

// File: tb/tb_imem_boot_loader.sv
// ----------------------------------------------------------------------------
// tb_imem_boot_loader
// Directed boot frames against imem_boot_loader. Expected memory writes are
// queued when a word is sent; a monitor pops and compares on every imem_we.
// ----------------------------------------------------------------------------
module tb_imem_boot_loader;
    import imem_boot_loader_pkg::*;

    localparam int ADDR_W = 8;

    logic              clk;
    logic              rst;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [WORD_W-1:0] imem_wdata;
    logic              cpu_rst;
    logic              done;
    logic              error;

    int assert_count = 0;
    int fail_count   = 0;

    logic [ADDR_W+WORD_W-1:0] exp_q[$];
    logic [ADDR_W-1:0]        exp_addr;
    logic                     prev_we;

    imem_boot_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_rst    (cpu_rst),
        .done       (done),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case a wait escapes its own bound.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Monitor: every write strobe must match the head of the expected queue
    // and must never last more than one cycle.
    always @(negedge clk) begin
        if (rst) begin
            prev_we <= 1'b0;
        end else begin
            if (imem_we) begin
                assert_count++;
                if (prev_we) begin
                    fail_count++;
                    $display("[TB] FAIL we_width: imem_we high for two cycles at addr %h", imem_addr);
                end
                if (exp_q.size() == 0) begin
                    assert_count++;
                    fail_count++;
                    $display("[TB] FAIL unexpected_write: addr %h data %h, expected no write",
                             imem_addr, imem_wdata);
                end else begin
                    logic [ADDR_W+WORD_W-1:0] e;
                    e = exp_q.pop_front();
                    checkOutput("write_addr", 32'(imem_addr), 32'(e[ADDR_W+WORD_W-1:WORD_W]));
                    checkOutput("write_data", imem_wdata, e[WORD_W-1:0]);
                end
            end
            prev_we <= imem_we;
        end
    end

    // Called at a negedge; the following posedge takes the byte.
    task automatic applyStimulus(input logic [7:0] b);
        int waited = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!rx_ready) begin
            assert_count++;
            fail_count++;
            $display("[TB] FAIL rx_timeout: rx_ready stayed %b, expected 1 for byte %h", rx_ready, b);
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        exp_q.push_back({exp_addr, w});
        exp_addr = exp_addr + 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic [31:0] tmp;
            tmp = w << (8 * i);
            applyStimulus(tmp[31:24]);
            if (i < 3) repeat (gap) @(negedge clk);
        end
        checkOutput("we_after_4th_byte", 32'(imem_we), 32'd1);
    endtask

    task automatic do_reset();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        rst      = 1'b1;
        exp_q.delete();
        exp_addr = '0;
        repeat (2) @(negedge clk);
        checkOutput("rst_rx_ready",   32'(rx_ready),   32'd0);
        checkOutput("rst_imem_we",    32'(imem_we),    32'd0);
        checkOutput("rst_imem_addr",  32'(imem_addr),  32'd0);
        checkOutput("rst_imem_wdata", imem_wdata,      32'd0);
        checkOutput("rst_cpu_rst",    32'(cpu_rst),    32'd1);
        checkOutput("rst_done",       32'(done),       32'd0);
        checkOutput("rst_error",      32'(error),      32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rx_ready_after_rst", 32'(rx_ready), 32'd1);
    endtask

    task automatic check_queue_empty(input string name);
        checkOutput(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        exp_addr = '0;
        prev_we  = 1'b0;

        // Good frame: N=2, words 20080005 and 2009000A. The XOR of the eight
        // payload bytes 20^08^00^05^20^09^00^0A is 0x0E.
        do_reset();
        applyStimulus(8'h00);
        applyStimulus(8'h02);
        send_word(32'h2008_0005, 0);
        send_word(32'h2009_000A, 0);
        checkOutput("good_rx_ready_check", 32'(rx_ready), 32'd1);
        checkOutput("good_cpu_rst_check",  32'(cpu_rst),  32'd1);
        applyStimulus(8'h0E);
        checkOutput("good_done",     32'(done),     32'd1);
        checkOutput("good_cpu_rst",  32'(cpu_rst),  32'd0);
        checkOutput("good_error",    32'(error),    32'd0);
        checkOutput("good_rx_ready", 32'(rx_ready), 32'd0);
        checkOutput("hold_addr",     32'(imem_addr), 32'd1);
        checkOutput("hold_wdata",    imem_wdata,     32'h2009_000A);
        check_queue_empty("good_all_writes");
        // Bytes offered in RUN must be ignored.
        rx_data  = 8'hFF;
        rx_valid = 1'b1;
        repeat (3) @(negedge clk);
        rx_valid = 1'b0;
        checkOutput("run_ignores_bytes", 32'(done), 32'd1);

        // Bad checksum on the same frame.
        do_reset();
        applyStimulus(8'h00);
        applyStimulus(8'h02);
        send_word(32'h2008_0005, 0);
        send_word(32'h2009_000A, 0);
        applyStimulus(8'h00);
        checkOutput("bad_error",    32'(error),    32'd1);
        checkOutput("bad_cpu_rst",  32'(cpu_rst),  32'd1);
        checkOutput("bad_rx_ready", 32'(rx_ready), 32'd0);
        checkOutput("bad_done",     32'(done),     32'd0);
        check_queue_empty("bad_all_writes");

        // Empty frame: done after the third byte, no writes.
        do_reset();
        applyStimulus(8'h00);
        applyStimulus(8'h00);
        checkOutput("n0_not_done_yet", 32'(done), 32'd0);
        applyStimulus(8'h00);
        checkOutput("n0_done",    32'(done),    32'd1);
        checkOutput("n0_cpu_rst", 32'(cpu_rst), 32'd0);
        checkOutput("n0_addr",    32'(imem_addr), 32'd0);

        // N = 256 exactly fits the memory and is accepted.
        do_reset();
        applyStimulus(8'h01);
        applyStimulus(8'h00);
        checkOutput("n256_error",    32'(error),    32'd0);
        checkOutput("n256_rx_ready", 32'(rx_ready), 32'd1);

        // N = 257 overflows the memory: abort right after LEN_LO.
        do_reset();
        applyStimulus(8'h01);
        applyStimulus(8'h01);
        checkOutput("n257_error",    32'(error),    32'd1);
        checkOutput("n257_rx_ready", 32'(rx_ready), 32'd0);
        checkOutput("n257_cpu_rst",  32'(cpu_rst),  32'd1);
        repeat (4) @(negedge clk);

        // rx_valid toggling every other cycle: N=1, word 8C080004,
        // checksum 8C^08^00^04 = 0x80.
        do_reset();
        applyStimulus(8'h00);
        applyStimulus(8'h01);
        send_word(32'h8C08_0004, 1);
        @(negedge clk);
        checkOutput("gap_we_low_after", 32'(imem_we), 32'd0);
        applyStimulus(8'h80);
        checkOutput("gap_done", 32'(done), 32'd1);
        check_queue_empty("gap_all_writes");

        // Reset after six payload bytes, then a full good frame.
        do_reset();
        applyStimulus(8'h00);
        applyStimulus(8'h02);
        send_word(32'h2008_0005, 0);
        applyStimulus(8'h20);
        applyStimulus(8'h09);
        @(negedge clk);
        check_queue_empty("mid_first_write");
        do_reset();
        applyStimulus(8'h00);
        applyStimulus(8'h02);
        send_word(32'h2008_0005, 0);
        send_word(32'h2009_000A, 0);
        applyStimulus(8'h0E);
        checkOutput("restart_done",    32'(done),    32'd1);
        checkOutput("restart_cpu_rst", 32'(cpu_rst), 32'd0);
        check_queue_empty("restart_all_writes");

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
